pixel_stream_serializer: RTL and testbench

- Sits directly downstream of the filter/magnitude mode mux.
- Accepts one 3-channel pixel per strobe and buffers it in a small FIFO.
- Emits the pixel one channel per word over a valid/ready handshake toward the output transport (UART/byte link).
- Decouples the burst-free, non-backpressurable filter pipeline from a slower, stalling sink.

---
 rtl/pixel_stream_serializer.sv | 157 +++++++++++++++
 tb/tb_pixel_stream_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_serializer.sv
// Buffers 3-channel pixels in a FIFO and emits them one channel word at a time over valid/ready.
// Optional PIXEL_CHECKSUM_EN appends a ch2^ch1^ch0 word to every pixel.
module pixel_stream_serializer #(
  parameter int unsigned COLOR_CHANNEL = 8,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [2:0][COLOR_CHANNEL-1:0] i_data,
  input  logic                          i_data_ready,
  output logic [COLOR_CHANNEL-1:0]      o_word,
  output logic                          o_word_valid,
  input  logic                          i_word_ready,
  output logic                          o_pixel_last,
  output logic                          o_fifo_full,
  output logic                          o_overflow
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
`ifdef PIXEL_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  logic [2:0][COLOR_CHANNEL-1:0] mem [FIFO_DEPTH];

  state_t                        state_q, state_d;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [1:0]                    idx_q, idx_d;
  logic [2:0][COLOR_CHANNEL-1:0] hold_q, hold_d;
  logic [COLOR_CHANNEL-1:0]      word_q, word_d;
  logic                          valid_q, valid_d;
  logic                          last_q, last_d;
  logic                          full_q, full_d;
  logic                          ovf_q, ovf_d;

  logic                          push, pop, xfer;
  logic [1:0]                    idx_nxt;
  logic [2:0][COLOR_CHANNEL-1:0] head;

  // Word order within a pixel: ch2, ch1, ch0, then optional checksum.
  function automatic logic [COLOR_CHANNEL-1:0] sel_word(
    input logic [2:0][COLOR_CHANNEL-1:0] px,
    input logic [1:0]                    idx
  );
    case (idx)
      2'd0:    return px[2];
      2'd1:    return px[1];
      2'd2:    return px[0];
`ifdef PIXEL_CHECKSUM_EN
      default: return px[2] ^ px[1] ^ px[0];
`else
      default: return '0;
`endif
    endcase
  endfunction

  assign head = mem[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    word_d   = word_q;
    valid_d  = valid_q;
    last_d   = last_q;
    pop      = 1'b0;
    xfer     = valid_q & i_word_ready;
    idx_nxt  = idx_q + 2'd1;

    case (state_q)
      IDLE: if (count_q != '0) pop = 1'b1;
      SEND: begin
        if (xfer) begin
          if (idx_q != LAST_IDX) begin
            idx_d  = idx_nxt;
            word_d = sel_word(hold_q, idx_nxt);
            last_d = (idx_nxt == LAST_IDX);
          end else if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = 2'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading a new pixel presents ch2 immediately, so back-to-back pixels have no bubble.
    if (pop) begin
      hold_d   = head;
      word_d   = head[2];
      valid_d  = 1'b1;
      last_d   = 1'b0;
      idx_d    = 2'd0;
      state_d  = SEND;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    push = i_data_ready & ((count_q != CW'(FIFO_DEPTH)) | pop);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CW'(FIFO_DEPTH));
    ovf_d   = ovf_q | (i_data_ready & ~push);
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_pixel_last = last_q;
  assign o_fifo_full  = full_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_pixel_stream_serializer.sv
// Scoreboard bench for pixel_stream_serializer: queue-level reference model, decoupled monitor.
module tb_pixel_stream_serializer;

  localparam int unsigned CC    = 8;
  localparam int unsigned DEPTH = 4;
`ifdef PIXEL_CHECKSUM_EN
  localparam int NWORDS = 4;
`else
  localparam int NWORDS = 3;
`endif

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic [2:0][CC-1:0] i_data = '0;
  logic               i_data_ready = 1'b0;
  logic [CC-1:0]      o_word;
  logic               o_word_valid;
  logic               i_word_ready = 1'b0;
  logic               o_pixel_last;
  logic               o_fifo_full;
  logic               o_overflow;

  pixel_stream_serializer #(.COLOR_CHANNEL(CC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_data_ready(i_data_ready),
    .o_word(o_word), .o_word_valid(o_word_valid), .i_word_ready(i_word_ready),
    .o_pixel_last(o_pixel_last), .o_fifo_full(o_fifo_full), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pending pixels, words left of the pixel being sent, sticky overflow.
  logic [2:0][CC-1:0] fifo_m[$];
  int                 inflight_n = 0;
  logic               ovf_m = 1'b0;
  logic [CC:0]        sb[$];
  logic               cur_valid = 1'b0, cur_full = 1'b0, cur_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs for the coming edge and advance the model through it.
  task automatic cycle(input logic stb, input logic [2:0][CC-1:0] px, input logic rdy);
    logic pop, push;
    @(posedge clk); #2;
    cur_valid = (inflight_n > 0);
    cur_full  = (fifo_m.size() == DEPTH);
    cur_ovf   = ovf_m;
    i_data_ready = stb;
    i_data       = px;
    i_word_ready = rdy;
    if (inflight_n > 0 && rdy) inflight_n--;
    pop  = (inflight_n == 0) && (fifo_m.size() > 0);
    push = stb && ((fifo_m.size() < DEPTH) || pop);
    if (pop) begin
      void'(fifo_m.pop_front());
      inflight_n = NWORDS;
    end
    if (push) begin
      fifo_m.push_back(px);
      sb.push_back({1'b0, px[2]});
      sb.push_back({1'b0, px[1]});
`ifdef PIXEL_CHECKSUM_EN
      sb.push_back({1'b0, px[0]});
      sb.push_back({1'b1, px[2] ^ px[1] ^ px[0]});
`else
      sb.push_back({1'b1, px[0]});
`endif
    end else if (stb) begin
      ovf_m = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    i_rst = 1'b1;
    i_data_ready = 1'b0;
    i_word_ready = 1'b0;
    #1;
    chk("rst_word", 32'(o_word), 32'h0);
    chk("rst_valid", 32'(o_word_valid), 32'h0);
    chk("rst_last", 32'(o_pixel_last), 32'h0);
    chk("rst_full", 32'(o_fifo_full), 32'h0);
    chk("rst_overflow", 32'(o_overflow), 32'h0);
    fifo_m.delete();
    sb.delete();
    inflight_n = 0;
    ovf_m = 1'b0;
    cur_valid = 1'b0; cur_full = 1'b0; cur_ovf = 1'b0;
    @(posedge clk); #2;
    i_rst = 1'b0;
  endtask

  function automatic logic [2:0][CC-1:0] rnd_px();
    logic [2:0][CC-1:0] p;
    p = {8'($urandom), 8'($urandom), 8'($urandom)};
    return p;
  endfunction

  // Monitor: compares state flags every cycle and pops the scoreboard on each transfer.
  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [CC-1:0] prev_word = '0;
  initial begin
    logic [CC:0] e;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        prev_valid = 1'b0;
        continue;
      end
      chk("valid", 32'(o_word_valid), 32'(cur_valid));
      chk("fifo_full", 32'(o_fifo_full), 32'(cur_full));
      chk("overflow", 32'(o_overflow), 32'(cur_ovf));
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", 32'(o_word_valid), 32'h1);
        chk("stall_word", 32'(o_word), 32'(prev_word));
        chk("stall_last", 32'(o_pixel_last), 32'(prev_last));
      end
      if (o_word_valid && i_word_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word act=%0h exp=none at %0t", o_word, $time);
        end else begin
          e = sb.pop_front();
          chk("word", 32'(o_word), 32'(e[CC-1:0]));
          chk("pixel_last", 32'(o_pixel_last), 32'(e[CC]));
        end
      end
      prev_valid = o_word_valid;
      prev_ready = i_word_ready;
      prev_word  = o_word;
      prev_last  = o_pixel_last;
    end
  end

  initial begin
    logic [2:0][CC-1:0] base;
    logic [2:0][CC-1:0] zero;
    base = {8'hAA, 8'h55, 8'h0F};
    zero = '0;
    do_reset();

    // Basic ordering
    cycle(1'b1, base, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, zero, 1'b1);

    // Back-to-back, one strobe every 3 cycles
    for (int p = 0; p < 4; p++) begin
      cycle(1'b1, rnd_px(), 1'b1);
      cycle(1'b0, zero, 1'b1);
      cycle(1'b0, zero, 1'b1);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, zero, 1'b1);

    // Stall after the first word is accepted
    cycle(1'b1, base, 1'b1);
    cycle(1'b0, zero, 1'b1);
    cycle(1'b0, zero, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, zero, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, zero, 1'b1);

    // Fill exactly to full, then push on the same edge as the last-word transfer
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, rnd_px(), 1'b0);
    cycle(1'b0, zero, 1'b0);
    cycle(1'b0, zero, 1'b1);
`ifdef PIXEL_CHECKSUM_EN
    cycle(1'b0, zero, 1'b1);
`endif
    cycle(1'b0, zero, 1'b1);
    cycle(1'b1, rnd_px(), 1'b1);
    cycle(1'b0, zero, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b0, zero, 1'b1);

    // Overflow: six strobes into a stalled sink, then drain
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, rnd_px(), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, zero, 1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b0, zero, 1'b1);

    // Reset mid-pixel with pixels queued; nothing may follow without new strobes
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd_px(), 1'b0);
    cycle(1'b0, zero, 1'b1);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, zero, 1'b1);

    // Randomized traffic: moderate load, then heavy load with a slow sink
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 99) < 30, rnd_px(), $urandom_range(0, 99) < 80);
    do_reset();
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 99) < 50, rnd_px(), $urandom_range(0, 99) < 50);

    for (int i = 0; i < 60; i++) cycle(1'b0, zero, 1'b1);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
